// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
// Holds the FSM state enum, one-hot operation codes, digit-enable patterns
// per state and error bit indices. No ports.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SHOW  = 3'd3,
    HALT  = 3'd4
  } state_t;

  // One-hot operation codes, same bit mapping as the button inputs
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0001;

  // Seven-segment digit enables per state
  localparam logic [3:0] SEG_IDLE  = 4'b0000;
  localparam logic [3:0] SEG_ISSUE = 4'b1100;
  localparam logic [3:0] SEG_WAIT  = 4'b1100;
  localparam logic [3:0] SEG_SHOW  = 4'b1111;
  localparam logic [3:0] SEG_HALT  = 4'b0000;

  // Error flag bit positions
  localparam int unsigned ERR_DIV0    = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  // Digit enable pattern for a given state
  function automatic logic [3:0] seg_for(input state_t s);
    case (s)
      ISSUE:   seg_for = SEG_ISSUE;
      WAIT:    seg_for = SEG_WAIT;
      SHOW:    seg_for = SEG_SHOW;
      HALT:    seg_for = SEG_HALT;
      default: seg_for = SEG_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_btn_edge_prio.sv
// Button rising-edge detector with fixed priority add > sub > mul > div.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   btn [3:0]     debounced button levels
//   press_c [3:0] one-hot highest-priority new press (combinational)
//   valid_c       at least one new press this cycle (combinational)
module btn_edge_prio
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [3:0] press_c,
  output logic       valid_c
);

  logic [3:0] btn_q;
  logic [3:0] rise;

  // Previous button levels; tracks btn in every state
  always_ff @(posedge clk) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

  // Priority encode the rising edges into a single one-hot op
  always_comb begin
    press_c = '0;
    valid_c = |rise;
    if      (rise[3]) press_c = OP_ADD;
    else if (rise[2]) press_c = OP_SUB;
    else if (rise[1]) press_c = OP_MUL;
    else if (rise[0]) press_c = OP_DIV;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Operation sequencer between switch/button inputs and a multi-cycle ALU.
// Latches operands on a button press, issues a one-cycle ALU start, waits
// for done with timeout protection and holds the result for the display.
// Divide-by-zero and timeout halts are left via clr_i.
// Optional build macro CALC_CHAIN_EN: presses from SHOW take operand A
// from the low bits of the held result instead of the switches.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sw_i                  operand switches, A = upper half, B = lower half
//   btn_i                 op buttons [3] add [2] sub [1] mul [0] div
//   clr_i                 clear result/errors, return to IDLE
//   alu_done_i, alu_res_i ALU completion pulse and result
//   alu_start_o, alu_op_o ALU start pulse and one-hot op
//   alu_a_o, alu_b_o      latched operands
//   result_o              last captured result
//   seg_sel_o             digit enables
//   err_o                 [0] divide-by-zero, [1] ALU timeout
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned OPND_W  = 4,
  parameter int unsigned RES_W   = 2 * OPND_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*OPND_W-1:0] sw_i,
  input  logic [3:0]          btn_i,
  input  logic                clr_i,
  input  logic                alu_done_i,
  input  logic [RES_W-1:0]    alu_res_i,
  output logic                alu_start_o,
  output logic [3:0]          alu_op_o,
  output logic [OPND_W-1:0]   alu_a_o,
  output logic [OPND_W-1:0]   alu_b_o,
  output logic [RES_W-1:0]    result_o,
  output logic [3:0]          seg_sel_o,
  output logic [1:0]          err_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_t              state_q, state_next;
  logic [CNT_W-1:0]    cnt_q, cnt_next;
  logic [RES_W-1:0]    result_next;
  logic [1:0]          err_next;
  logic [OPND_W-1:0]   a_next, b_next;
  logic [3:0]          op_next;
  logic [3:0]          press_c;
  logic                press_valid_c;
  logic [OPND_W-1:0]   sw_a, sw_b;

  assign sw_a = sw_i[2*OPND_W-1:OPND_W];
  assign sw_b = sw_i[OPND_W-1:0];

  btn_edge_prio u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_i),
    .press_c (press_c),
    .valid_c (press_valid_c)
  );

  // State and output registers; outputs follow the next state so they are
  // aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_o    <= '0;
      err_o       <= '0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_op_o    <= '0;
      alu_start_o <= 1'b0;
      seg_sel_o   <= '0;
    end else begin
      state_q     <= state_next;
      cnt_q       <= cnt_next;
      result_o    <= result_next;
      err_o       <= err_next;
      alu_a_o     <= a_next;
      alu_b_o     <= b_next;
      alu_op_o    <= (state_next == ISSUE || state_next == WAIT) ? op_next : 4'b0000;
      alu_start_o <= (state_next == ISSUE);
      seg_sel_o   <= seg_for(state_next);
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    state_next  = state_q;
    cnt_next    = '0;
    result_next = result_o;
    err_next    = err_o;
    a_next      = alu_a_o;
    b_next      = alu_b_o;
    op_next     = alu_op_o;

    if (clr_i) begin
      // Any coincident press is dropped; operands stay latched
      state_next  = IDLE;
      result_next = '0;
      err_next    = '0;
    end else begin
      case (state_q)
        IDLE, SHOW: begin
          if (press_valid_c) begin
`ifdef CALC_CHAIN_EN
            a_next = (state_q == SHOW) ? result_o[OPND_W-1:0] : sw_a;
`else
            a_next = sw_a;
`endif
            b_next  = sw_b;
            op_next = press_c;
            if (press_c == OP_DIV && sw_b == '0) begin
              state_next         = HALT;
              err_next[ERR_DIV0] = 1'b1;
            end else begin
              state_next = ISSUE;
            end
          end
        end
        ISSUE: state_next = WAIT;
        WAIT: begin
          // Done wins over a timeout in the same cycle
          if (alu_done_i) begin
            result_next = alu_res_i;
            state_next  = SHOW;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_next            = HALT;
            err_next[ERR_TIMEOUT] = 1'b1;
          end else begin
            cnt_next = cnt_q + CNT_W'(1);
          end
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
